// File: rtl/q_table_player.sv
// q_table_player: on-chip Q-factor table with a load port and a valid/ready
// playback engine (one-shot or looped) with a programmable per-sample hold.

module q_table_player #(
  parameter int  Q_WIDTH = 16,
  parameter int  DEPTH   = 256,
  parameter int  HOLD_W  = 8,
  parameter int  WRAP_W  = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_en_i,
  input  logic [AW-1:0]      load_addr_i,
  input  logic [Q_WIDTH-1:0] load_data_i,
  output logic               load_err_o,
  input  logic [AW:0]        len_i,
  input  logic               loop_mode_i,
  input  logic [HOLD_W-1:0]  hold_cycles_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic [Q_WIDTH-1:0] q_out_o,
  output logic [AW-1:0]      q_index_o,
  output logic               q_valid_o,
  input  logic               q_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WRAP_W-1:0]  wrap_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Table storage; deliberately not reset so contents survive rst.
  logic [Q_WIDTH-1:0] mem_q [DEPTH];

  state_e              state_q;
  logic [AW:0]         len_q;
  logic                loop_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   holdCnt_q;
  logic [AW-1:0]       index_q;
  logic [WRAP_W-1:0]   wrap_count_q;
  logic [Q_WIDTH-1:0]  q_out_q;
  logic [AW-1:0]       q_index_q;
  logic                q_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                load_err_q;

  logic                isLast_d;
  logic                lenOk_d;
  logic [WRAP_W-1:0]   wrapNext_d;
  state_e              advState_d;
  logic [AW-1:0]       advIndex_d;
  logic [WRAP_W-1:0]   advWrap_d;
  logic                advDone_d;

  // Writes only land while idle so a running playback never sees torn data.
  always_ff @(posedge clk_i) begin
    if (load_en_i && (state_q == ST_IDLE)) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // Flag a write attempted while busy; it shows up the cycle after.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_en_i && (state_q != ST_IDLE);
    end
  end

  // ADVANCE action shared by PRESENT (no hold) and the end of HOLD.
  always_comb begin
    lenOk_d    = (len_i != '0) && (len_i <= DEPTH_L);
    isLast_d   = ({1'b0, index_q} == (len_q - (AW+1)'(1)));
    wrapNext_d = (&wrap_count_q) ? wrap_count_q : (wrap_count_q + WRAP_W'(1));
    advState_d = ST_FETCH;
    advIndex_d = index_q + AW'(1);
    advWrap_d  = wrap_count_q;
    advDone_d  = 1'b0;
    if (isLast_d) begin
      if (loop_q) begin
        advIndex_d = '0;
        advWrap_d  = wrapNext_d;
      end else begin
        advState_d = ST_DONE;
        advIndex_d = index_q;
        advDone_d  = 1'b1;
      end
    end
  end

  // Playback FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      loop_q       <= 1'b0;
      hold_q       <= '0;
      holdCnt_q    <= '0;
      index_q      <= '0;
      wrap_count_q <= '0;
      q_out_q      <= '0;
      q_index_q    <= '0;
      q_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q   <= ST_IDLE;
        q_valid_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              if (lenOk_d) begin
                len_q        <= len_i;
                loop_q       <= loop_mode_i;
                hold_q       <= hold_cycles_i;
                index_q      <= '0;
                wrap_count_q <= '0;
                busy_q       <= 1'b1;
                state_q      <= ST_FETCH;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            q_out_q   <= mem_q[index_q];
            q_index_q <= index_q;
            q_valid_q <= 1'b1;
            state_q   <= ST_PRESENT;
          end
          ST_PRESENT: begin
            if (q_ready_i) begin
              q_valid_q <= 1'b0;
              if (hold_q == '0) begin
                state_q      <= advState_d;
                index_q      <= advIndex_d;
                wrap_count_q <= advWrap_d;
                done_q       <= advDone_d;
              end else begin
                holdCnt_q <= hold_q;
                state_q   <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (holdCnt_q == HOLD_W'(1)) begin
              state_q      <= advState_d;
              index_q      <= advIndex_d;
              wrap_count_q <= advWrap_d;
              done_q       <= advDone_d;
            end else begin
              holdCnt_q <= holdCnt_q - HOLD_W'(1);
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q    <= 1'b0;
            q_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign load_err_o   = load_err_q;
  assign q_out_o      = q_out_q;
  assign q_index_o    = q_index_q;
  assign q_valid_o    = q_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign wrap_count_o = wrap_count_q;

endmodule
